line_buffer_frame_sequencer: RTL and testbench

// Sequences one video frame into the 4-line triple-read line buffer for the 3x3 convolution engine.

---
 rtl/line_buffer_frame_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_line_buffer_frame_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_frame_sequencer.sv
// Frame sequencer for the 4-line line buffer feeding the 3x3 convolution core.
// Frames a raster pixel stream with one top and two bottom pad lines, drives
// the buffer write/clear controls and tags each completed 3x3 window.
module line_buffer_frame_sequencer #(
    parameter int               IMG_WIDTH    = 640,
    parameter int               IMG_HEIGHT   = 480,
    parameter int               PIX_W        = 16,
    parameter logic [PIX_W-1:0] PAD_VALUE    = '0,
    parameter int               FLUSH_CYCLES = 4
) (
    input  logic                          write_clk,
    input  logic                          reset_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [PIX_W-1:0]              s_data,
    input  logic                          s_sof,
    input  logic                          s_eol,
    output logic                          lb_write,
    output logic [PIX_W-1:0]              lb_pixel,
    output logic                          lb_reset_n,
    output logic                          win_valid,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
    output logic                          win_border,
    output logic                          frame_done,
    output logic                          err_line,
    output logic                          err_sof
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    // line counter must reach H+3 after the final pad beat without wrapping
    localparam int WW = $clog2(IMG_HEIGHT + 4);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
    localparam logic [WW-1:0] W_IMG_LAST = WW'(IMG_HEIGHT);
    localparam logic [WW-1:0] W_PAD_LAST = WW'(IMG_HEIGHT + 2);
    localparam logic [WW-1:0] W_WIN_MIN  = WW'(3);
    localparam logic [FW-1:0] FL_LAST    = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {FLUSH, IDLE, TOPPAD, RUN, BOTPAD} state_t;

    state_t            state, nxt;
    logic [FW-1:0]     flush_cnt;
    logic [CW-1:0]     col;
    logic [WW-1:0]     w;
    logic [PIX_W-1:0]  hold_pix;
    logic              hold_eol;

    logic              beat, eol_chk, beat_eol, sof_take, abort, done;
    logic [PIX_W-1:0]  beat_pix;
    logic              line_end;

    logic [1:0]        vld_pipe;
    logic [RW-1:0]     tag_row;
    logic [CW-1:0]     tag_col;

    assign line_end   = (col == COL_LAST);
    assign lb_reset_n = (state != FLUSH);
    assign win_valid  = vld_pipe[1];

    // state register
    always_ff @(posedge write_clk) begin
        if (!reset_n) state <= FLUSH;
        else          state <= nxt;
    end

    // next state, beat generation and handshake
    always_comb begin
        nxt      = state;
        s_ready  = 1'b0;
        beat     = 1'b0;
        beat_pix = PAD_VALUE;
        eol_chk  = 1'b0;
        beat_eol = 1'b0;
        sof_take = 1'b0;
        abort    = 1'b0;
        done     = 1'b0;
        case (state)
            FLUSH: if (flush_cnt == FL_LAST) nxt = IDLE;
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid && s_sof) begin
                    sof_take = 1'b1;
                    nxt      = TOPPAD;
                end
            end
            TOPPAD: begin
                beat = 1'b1;
                // after the pad line wraps, the held sof pixel goes out at (1,0)
                if (w == WW'(1)) begin
                    beat_pix = hold_pix;
                    eol_chk  = 1'b1;
                    beat_eol = hold_eol;
                    nxt      = RUN;
                end
            end
            RUN: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (s_sof) begin
                        abort = 1'b1;
                        nxt   = FLUSH;
                    end else begin
                        beat     = 1'b1;
                        beat_pix = s_data;
                        eol_chk  = 1'b1;
                        beat_eol = s_eol;
                        if (w == W_IMG_LAST && line_end) nxt = BOTPAD;
                    end
                end
            end
            BOTPAD: begin
                beat = 1'b1;
                if (w == W_PAD_LAST && line_end) begin
                    done = 1'b1;
                    nxt  = FLUSH;
                end
            end
            default: nxt = FLUSH;
        endcase
    end

    // counters, held sof pixel, buffer write port and error flags
    always_ff @(posedge write_clk) begin
        if (!reset_n) begin
            flush_cnt  <= '0;
            col        <= '0;
            w          <= '0;
            hold_pix   <= '0;
            hold_eol   <= 1'b0;
            lb_write   <= 1'b0;
            lb_pixel   <= '0;
            err_line   <= 1'b0;
            err_sof    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            flush_cnt  <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
            lb_write   <= beat;
            err_sof    <= abort;
            frame_done <= done;
            if (beat) lb_pixel <= beat_pix;
            if (sof_take) begin
                hold_pix <= s_data;
                hold_eol <= s_eol;
                col      <= '0;
                w        <= '0;
            end else if (beat) begin
                if (line_end) begin
                    col <= '0;
                    w   <= w + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            // the column counter is authoritative; a misplaced or missing eol only flags
            if (beat && eol_chk && (beat_eol != line_end)) err_line <= 1'b1;
        end
    end

    // two-stage window tag pipeline; an abort kills the tag still in flight
    always_ff @(posedge write_clk) begin
        if (!reset_n) begin
            vld_pipe   <= '0;
            tag_row    <= '0;
            tag_col    <= '0;
            win_row    <= '0;
            win_col    <= '0;
            win_border <= 1'b0;
        end else begin
            vld_pipe[0] <= beat && (w >= W_WIN_MIN);
            vld_pipe[1] <= vld_pipe[0] & ~abort;
            tag_row     <= RW'(w - W_WIN_MIN);
            tag_col     <= col;
            if (vld_pipe[0] & ~abort) begin
                win_row    <= tag_row;
                win_col    <= tag_col;
                win_border <= (tag_row == '0) || (tag_row == ROW_LAST) ||
                              (tag_col == '0) || (tag_col == COL_LAST);
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_frame_sequencer.sv
// Scoreboard bench for line_buffer_frame_sequencer at W=4, H=3.
module tb_line_buffer_frame_sequencer;

    localparam int          W   = 4;
    localparam int          H   = 3;
    localparam int          PW  = 16;
    localparam logic [15:0] PAD = 16'h0055;

    logic          write_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [PW-1:0] s_data = '0;
    logic          s_sof = 1'b0;
    logic          s_eol = 1'b0;
    logic          lb_write;
    logic [PW-1:0] lb_pixel;
    logic          lb_reset_n;
    logic          win_valid;
    logic [1:0]    win_row;
    logic [1:0]    win_col;
    logic          win_border;
    logic          frame_done;
    logic          err_line;
    logic          err_sof;

    line_buffer_frame_sequencer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW), .PAD_VALUE(PAD), .FLUSH_CYCLES(4)
    ) dut (
        .write_clk(write_clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol), .lb_write(lb_write),
        .lb_pixel(lb_pixel), .lb_reset_n(lb_reset_n), .win_valid(win_valid),
        .win_row(win_row), .win_col(win_col), .win_border(win_border),
        .frame_done(frame_done), .err_line(err_line), .err_sof(err_sof)
    );

    always #5 write_clk = ~write_clk;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
        logic       border;
    } win_t;

    logic [PW-1:0] exp_pix[$];
    win_t          exp_win[$];
    int n_cmp = 0, n_bad = 0;
    int wr_cnt = 0, win_cnt = 0, fd_cnt = 0, es_cnt = 0;

    function automatic logic [15:0] pix(input int r, input int c);
        return 16'(32'h1000 + r * 16 + c);
    endfunction

    function automatic win_t mk_win(input int r, input int c);
        win_t x;
        x.row    = 2'(r);
        x.col    = 2'(c);
        x.border = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
        return x;
    endfunction

    task automatic clr_counts();
        wr_cnt = 0; win_cnt = 0; fd_cnt = 0; es_cnt = 0;
    endtask

    task automatic push_frame_exp();
        for (int c = 0; c < W; c++) exp_pix.push_back(PAD);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                exp_pix.push_back(pix(r, c));
                exp_win.push_back(mk_win(r, c));
            end
        for (int c = 0; c < 2 * W; c++) exp_pix.push_back(PAD);
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic put_pix(input logic [15:0] d, input logic sof, input logic eol);
        int t = 0;
        s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
        while (!s_ready && t < 200) begin @(negedge write_clk); t++; end
        if (t >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL put_pix_timeout: s_ready=%b after %0d cycles, required 1", s_ready, t);
        end
        @(negedge write_clk);
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    endtask

    task automatic drive_rows(input int duty, input int bad_r, input int bad_c,
                              input int last_r, input int last_c);
        for (int r = 0; r <= last_r; r++)
            for (int c = 0; c < W; c++) begin
                if (r == last_r && c > last_c) break;
                while (duty < 100 && int'($urandom_range(99)) >= duty) @(negedge write_clk);
                put_pix(pix(r, c), (r == 0 && c == 0), (c == W - 1) || (r == bad_r && c == bad_c));
            end
    endtask

    task automatic wait_done();
        int t = 0;
        while (fd_cnt == 0 && t < 100) begin @(negedge write_clk); t++; end
        repeat (4) @(negedge write_clk);
    endtask

    task automatic test_reset();
        int lows = 0;
        repeat (3) @(posedge write_clk);
        @(negedge write_clk);
        n_cmp++; if ({lb_reset_n, s_ready, lb_write, win_valid, frame_done, err_line, err_sof} !== 7'b0) begin
            n_bad++; $display("FAIL reset_outputs: rstn/rdy/wr/wv/fd/el/es=%b required 0000000",
                {lb_reset_n, s_ready, lb_write, win_valid, frame_done, err_line, err_sof});
        end
        reset_n = 1'b1;
        while (lb_reset_n === 1'b0 && lows < 20) begin lows++; @(negedge write_clk); end
        n_cmp++; if (lows !== 4) begin n_bad++; $display("FAIL flush_len: %0d cycles low, required 4", lows); end
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: s_ready=%b required 1", s_ready); end
        repeat (5) @(negedge write_clk);
        n_cmp++; if (wr_cnt !== 0) begin n_bad++; $display("FAIL idle_no_write: %0d writes, required 0", wr_cnt); end
    endtask

    task automatic check_frame_totals(input string tag, input int wr, input int wv, input int fd);
        n_cmp++; if (wr_cnt !== wr) begin n_bad++; $display("FAIL %s_writes: %0d, required %0d", tag, wr_cnt, wr); end
        n_cmp++; if (win_cnt !== wv) begin n_bad++; $display("FAIL %s_windows: %0d, required %0d", tag, win_cnt, wv); end
        n_cmp++; if (fd_cnt !== fd) begin n_bad++; $display("FAIL %s_frame_done: %0d, required %0d", tag, fd_cnt, fd); end
        n_cmp++; if (exp_pix.size() + exp_win.size() !== 0) begin
            n_bad++; $display("FAIL %s_drain: %0d pixels %0d windows outstanding, required 0", tag, exp_pix.size(), exp_win.size());
        end
    endtask

    task automatic test_frame();
        clr_counts(); push_frame_exp();
        drive_rows(100, -1, -1, H - 1, W - 1);
        wait_done();
        check_frame_totals("frame", W * (H + 3), W * H, 1);
        n_cmp++; if (err_line !== 1'b0) begin n_bad++; $display("FAIL frame_err_line: %b required 0", err_line); end
    endtask

    task automatic test_random_valid();
        clr_counts(); push_frame_exp();
        drive_rows(50, -1, -1, H - 1, W - 1);
        wait_done();
        check_frame_totals("random", W * (H + 3), W * H, 1);
    endtask

    task automatic test_idle_discard();
        clr_counts();
        for (int i = 0; i < 5; i++) put_pix(16'hBEE0 + 16'(i), 1'b0, 1'b0);
        push_frame_exp();
        drive_rows(100, -1, -1, H - 1, W - 1);
        wait_done();
        check_frame_totals("discard", W * (H + 3), W * H, 1);
    endtask

    task automatic test_eol_error();
        clr_counts(); push_frame_exp();
        drive_rows(100, 1, 2, H - 1, W - 1);
        wait_done();
        n_cmp++; if (err_line !== 1'b1) begin n_bad++; $display("FAIL eol_err_set: %b required 1", err_line); end
        check_frame_totals("eol", W * (H + 3), W * H, 1);
        repeat (10) @(negedge write_clk);
        n_cmp++; if (err_line !== 1'b1) begin n_bad++; $display("FAIL eol_err_sticky: %b required 1", err_line); end
    endtask

    task automatic test_sof_abort();
        int lows = 0;
        clr_counts();
        for (int c = 0; c < W; c++) exp_pix.push_back(PAD);
        for (int c = 0; c < W; c++) exp_pix.push_back(pix(0, c));
        exp_pix.push_back(pix(1, 0));
        drive_rows(100, -1, -1, 1, 0);
        put_pix(pix(1, 1), 1'b1, 1'b0);
        n_cmp++; if (err_sof !== 1'b1) begin n_bad++; $display("FAIL abort_err_sof: %b required 1", err_sof); end
        while (lb_reset_n === 1'b0 && lows < 20) begin lows++; @(negedge write_clk); end
        n_cmp++; if (lows !== 4) begin n_bad++; $display("FAIL abort_flush_len: %0d, required 4", lows); end
        repeat (20) @(negedge write_clk);
        n_cmp++; if (es_cnt !== 1) begin n_bad++; $display("FAIL abort_err_sof_pulses: %0d, required 1", es_cnt); end
        check_frame_totals("abort", 9, 0, 0);
        clr_counts(); push_frame_exp();
        drive_rows(100, -1, -1, H - 1, W - 1);
        wait_done();
        check_frame_totals("after_abort", W * (H + 3), W * H, 1);
    endtask

    task automatic test_reset_midrun();
        clr_counts();
        for (int c = 0; c < W; c++) exp_pix.push_back(PAD);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++) exp_pix.push_back(pix(r, c));
        exp_pix.push_back(pix(2, 0));
        exp_pix.push_back(pix(2, 1));
        exp_win.push_back(mk_win(0, 0));
        drive_rows(100, -1, -1, 2, 1);
        reset_n = 1'b0;
        @(negedge write_clk);
        n_cmp++; if ({lb_reset_n, s_ready, lb_write, win_valid, frame_done, err_line, err_sof, win_border} !== 8'b0) begin
            n_bad++; $display("FAIL midrun_reset_flags: %b required 00000000",
                {lb_reset_n, s_ready, lb_write, win_valid, frame_done, err_line, err_sof, win_border});
        end
        n_cmp++; if ({lb_pixel, win_row, win_col} !== 20'h0) begin
            n_bad++; $display("FAIL midrun_reset_data: pix=%h row=%0d col=%0d required 0", lb_pixel, win_row, win_col);
        end
        reset_n = 1'b1;
        repeat (10) @(negedge write_clk);
        check_frame_totals("midrun", 14, 1, 0);
    endtask

    initial begin
        fork
            begin : monitor
                logic [PW-1:0] ep;
                win_t          ew, aw;
                logic          prev_wr;
                prev_wr = 1'b0;
                forever begin
                    @(negedge write_clk);
                    if (lb_write === 1'b1) begin
                        wr_cnt++; n_cmp++;
                        if (exp_pix.size() == 0) begin
                            n_bad++; $display("FAIL lb_pixel_extra: got %h, none expected", lb_pixel);
                        end else begin
                            ep = exp_pix.pop_front();
                            if (lb_pixel !== ep) begin n_bad++; $display("FAIL lb_pixel: got %h, required %h", lb_pixel, ep); end
                        end
                    end
                    if (win_valid === 1'b1) begin
                        win_cnt++; n_cmp++;
                        aw = '{row: win_row, col: win_col, border: win_border};
                        if (exp_win.size() == 0) begin
                            n_bad++; $display("FAIL win_extra: got row %0d col %0d, none expected", win_row, win_col);
                        end else begin
                            ew = exp_win.pop_front();
                            if (aw !== ew) begin
                                n_bad++; $display("FAIL win_tag: got r%0d c%0d b%b, required r%0d c%0d b%b",
                                    aw.row, aw.col, aw.border, ew.row, ew.col, ew.border);
                            end
                        end
                        n_cmp++;
                        if (prev_wr !== 1'b1) begin n_bad++; $display("FAIL win_spacing: lb_write one cycle earlier=%b, required 1", prev_wr); end
                    end
                    if (frame_done === 1'b1) fd_cnt++;
                    if (err_sof === 1'b1) es_cnt++;
                    prev_wr = lb_write;
                end
            end
        join_none
        test_reset();
        test_frame();
        test_random_valid();
        test_idle_discard();
        test_eol_error();
        test_sof_abort();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
